pkt_src_arb: RTL and testbench

- Round-robin scheduler that shares one downstream 16-bit packet interface (UDP/IP payload input) between N packet sources of the en/busy/rdy/sop/eop/vld/mty type.
- Starts one source at a time with a single-cycle en pulse and routes downstream rdy to that source only.
- Forwards the granted source's stream to the output with one cycle of latency, then enforces an inter-packet gap.
- A watchdog recovers from a source that stalls mid-packet.

---
 rtl/pkt_src_arb_pkg.sv | 18 +
 rtl/rr_arb_n.sv | 42 ++++
 rtl/pkt_src_arb.sv | 182 ++++++++++++++++++
 tb/tb_pkt_src_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_src_arb_pkg.sv
// Shared types and helpers for the packet-source round-robin scheduler.
package pkt_src_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_DW = 16;

    // Index reached by stepping 'step' places past 'cur' in a ring of n.
    function automatic int rr_next(input int cur, input int step, input int n);
        return (cur + step) % n;
    endfunction

endpackage

// File: rtl/rr_arb_n.sv
// N-way round-robin picker: combinational search starting after the last winner.
// Pointer register moves to the winner only when i_take is asserted; no backpressure of its own.
module rr_arb_n
    import pkt_src_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_elig,
    input  logic          i_take,
    output logic          o_any,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_any  = 1'b0;
        o_idx  = r_ptr;
        w_cand = r_ptr;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'(rr_next(int'(r_ptr), k, N));
            if (!o_any && i_elig[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

    // Reset to N-1 so that source 0 is the first one searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (i_take) begin
            r_ptr <= o_idx;
        end
    end

endmodule

// File: rtl/pkt_src_arb.sv
// Round-robin scheduler sharing one downstream packet port among N sources; 1-cycle data latency.
// Downstream rdy is passed combinationally to the granted source only; a watchdog aborts stalled packets.
module pkt_src_arb
    import pkt_src_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int DW      = DEF_DW,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    src_en,
    input  logic [N-1:0]    src_busy,
    output logic [N-1:0]    src_rdy,
    input  logic [N*DW-1:0] src_din,
    input  logic [N-1:0]    src_vld,
    input  logic [N-1:0]    src_sop,
    input  logic [N-1:0]    src_eop,
    input  logic [N-1:0]    src_mty,
    output logic [DW-1:0]   dout,
    output logic            dout_vld,
    output logic            dout_sop,
    output logic            dout_eop,
    output logic            dout_mty,
    input  logic            rdy,
    output logic [N-1:0]    grant,
    output logic            err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_grant, r_en;
    logic            r_err;
    logic [WW-1:0]   r_wd;
    logic [GW-1:0]   r_gap;
    logic [DW-1:0]   r_dout;
    logic            r_vld, r_sop, r_eop, r_mty;

    logic [N-1:0]    w_elig;
    logic            w_any, w_take, w_abort, w_xfer;
    logic [IW-1:0]   w_idx;
    logic [DW-1:0]   w_din;
    logic            w_vld, w_sop, w_eop, w_mty;

    assign w_elig = req & ~src_busy;

    rr_arb_n #(.N(N), .IW(IW)) u_rr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_elig (w_elig),
        .i_take (w_take),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    // Only the owner's inputs are looked at; everyone else is masked out.
    always_comb begin
        w_din = '0;
        w_vld = 1'b0;
        w_sop = 1'b0;
        w_eop = 1'b0;
        w_mty = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_din = src_din[i*DW +: DW];
                w_vld = src_vld[i];
                w_sop = src_sop[i];
                w_eop = src_eop[i];
                w_mty = src_mty[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: w_state_nxt = ST_XFER;
            ST_XFER: begin
                // An end-of-packet beat takes priority over a coincident timeout.
                if (w_vld && w_eop) begin
                    w_state_nxt = ST_GAP;
                end else if (!w_vld && rdy && r_wd == WD_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_xfer  = (r_state == ST_XFER);
    assign src_rdy = (w_xfer && rdy) ? r_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_en    <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
            r_gap   <= '0;
        end else begin
            r_en  <= '0;
            r_err <= w_abort;
            if (w_take) begin
                r_grant <= ONE << w_idx;
                r_en    <= ONE << w_idx;
            end else if (r_state == ST_GAP && r_gap == GAP_LAST) begin
                r_grant <= '0;
            end

            if (!w_xfer || w_vld || w_abort) begin
                r_wd <= '0;
            end else if (rdy) begin
                r_wd <= r_wd + 1'b1;
            end

            if (r_state == ST_GAP && r_gap != GAP_LAST) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end

    // Data holds its last value; qualifiers drop to zero when nothing is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_mty  <= 1'b0;
        end else begin
            r_vld <= w_xfer && w_vld;
            r_sop <= w_xfer && w_vld && w_sop;
            r_eop <= w_xfer && w_vld && w_eop;
            r_mty <= w_xfer && w_vld && w_mty;
            if (w_xfer && w_vld) begin
                r_dout <= w_din;
            end
        end
    end

    assign src_en   = r_en;
    assign grant    = r_grant;
    assign err      = r_err;
    assign dout     = r_dout;
    assign dout_vld = r_vld;
    assign dout_sop = r_sop;
    assign dout_eop = r_eop;
    assign dout_mty = r_mty;

endmodule

// File: tb/tb_pkt_src_arb.sv
// Scoreboard bench for pkt_src_arb: two data-generator sources, directed scenarios.
module tb_pkt_src_arb;

    localparam int GAP = 4;
    localparam int TO  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, src_en, src_busy, src_rdy, src_vld, src_sop, src_eop, src_mty, grant;
    logic [31:0] src_din;
    logic [15:0] dout;
    logic        dout_vld, dout_sop, dout_eop, dout_mty, rdy, err;

    always #5 clk = ~clk;

    pkt_src_arb #(.N(2), .DW(16), .GAP(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .src_en(src_en), .src_busy(src_busy),
        .src_rdy(src_rdy), .src_din(src_din), .src_vld(src_vld), .src_sop(src_sop),
        .src_eop(src_eop), .src_mty(src_mty), .dout(dout), .dout_vld(dout_vld),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_mty(dout_mty), .rdy(rdy),
        .grant(grant), .err(err)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic [15:0] dat;
        logic        sop;
        logic        eop;
        logic        mty;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_act, mon_exp;
    int    vectors = 0, miscompares = 0;
    int    cyc = 0, beats = 0, err_cnt = 0, err_gap = -1;
    int    last_beat_cyc = 0, eop_cyc = 0, grant0_cyc = 0;
    int    en_hist[$];
    bit    have_eop = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    // Source model state and scenario knobs
    logic [1:0] s_act;
    int         s_b[2];
    logic       stall0, spur0, fbusy0;

    function automatic logic [15:0] gen(input int i, input int k);
        logic [7:0] hi, lo;
        lo  = 8'h41 + 8'(k);
        hi  = (k == 0) ? 8'h00 : 8'h40 + 8'(k);
        gen = {hi, lo} ^ ((i == 1) ? 16'h8000 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pkt(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.gnt = (src == 1) ? 2'b10 : 2'b01;
            b.dat = gen(src, k);
            b.sop = (k == 0);
            b.eop = (k == 25);
            b.mty = (k == 0);
            sb_q.push_back(b);
        end
    endtask

    function automatic int en_at(input int k);
        return (k < en_hist.size()) ? en_hist[k] : -1;
    endfunction

    task automatic wait_en(input int target, input int bound, input string name);
        int t;
        t = 0;
        while (en_hist.size() < target && t < bound) begin
            step();
            t++;
        end
        if (en_hist.size() < target) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: only %0d src_en pulses seen, expected %0d", name, en_hist.size(), target);
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || grant != 2'b00) && t < bound) begin
            step();
            t++;
        end
        if (sb_q.size() != 0 || grant != 2'b00) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d beats outstanding, grant=%b, expected 0 and 00", name, sb_q.size(), grant);
        end
    endtask

    always_comb begin
        src_vld  = '0;
        src_sop  = '0;
        src_eop  = '0;
        src_mty  = '0;
        src_din  = '0;
        src_busy = s_act;
        src_busy[0] = s_act[0] | fbusy0;
        for (int i = 0; i < 2; i++) begin
            if (s_act[i] && src_rdy[i] && s_b[i] < ((i == 0 && stall0) ? 3 : 26)) begin
                src_vld[i]            = 1'b1;
                src_din[i*16 +: 16]   = gen(i, s_b[i]);
                src_sop[i]            = (s_b[i] == 0);
                src_eop[i]            = (s_b[i] == 25);
                src_mty[i]            = (s_b[i] == 0);
            end
        end
        if (spur0 && !grant[0]) begin
            src_vld[0]     = 1'b1;
            src_sop[0]     = 1'b1;
            src_eop[0]     = 1'b1;
            src_din[15:0]  = 16'hDEAD;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_act  <= 2'b00;
            s_b[0] <= 0;
            s_b[1] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (src_en[i]) begin
                    s_act[i] <= 1'b1;
                    s_b[i]   <= 0;
                end else if (s_act[i]) begin
                    if (!grant[i]) begin
                        s_act[i] <= 1'b0;
                    end else if (src_vld[i]) begin
                        s_b[i] <= s_b[i] + 1;
                        if (s_b[i] == 25) s_act[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every forwarded beat and checks port invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rdy_only_to_owner", 32'(src_rdy & ~grant), 0);
            chk("rdy_needs_downstream", 32'((|src_rdy) & ~rdy), 0);
            chk("en_only_to_owner", 32'(src_en & ~grant), 0);
            chk("qualifier_without_vld", 32'((dout_sop | dout_eop | dout_mty) & ~dout_vld), 0);
            if (src_en != 2'b00) begin
                en_hist.push_back(src_en[1] ? 1 : 0);
                if (have_eop) begin
                    chk("eop_to_next_en_gap", 32'((cyc - eop_cyc) >= GAP + 1), 1);
                    have_eop = 1'b0;
                end
            end
            if (dout_vld) begin
                beats++;
                last_beat_cyc = cyc;
                mon_act = {grant, dout, dout_sop, dout_eop, dout_mty};
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got 0x%0h with nothing expected", mon_act);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("beat", 32'(mon_act), 32'(mon_exp));
                end
                if (dout_eop) begin
                    have_eop = 1'b1;
                    eop_cyc  = cyc;
                end
            end
            if (err) begin
                err_cnt++;
                err_gap = cyc - last_beat_cyc;
            end
            if (grant == 2'b00 && prev_grant != 2'b00) grant0_cyc = cyc;
            prev_grant = grant;
        end
    end

    initial begin
        int base, t;
        rst_n = 1'b0; req = 2'b00; rdy = 1'b0;
        stall0 = 1'b0; spur0 = 1'b0; fbusy0 = 1'b0;
        repeat (3) step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_src_en", 32'(src_en), 0);
        chk("rst_src_rdy", 32'(src_rdy), 0);
        chk("rst_dout_vld", 32'(dout_vld), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        rdy   = 1'b1;
        step();

        // Single source
        push_pkt(0, 26);
        req = 2'b01;
        wait_en(1, 50, "t1_start");
        chk("t1_en_src", 32'(en_at(0)), 0);
        req = 2'b00;
        wait_idle(200, "t1_drain");
        chk("t1_eop_to_grant_clear", 32'(grant0_cyc - eop_cyc), GAP);
        chk("t1_single_en", 32'(en_hist.size()), 1);

        // Both requesting: pointer sits on 0, so 1 goes next
        push_pkt(1, 26); push_pkt(0, 26); push_pkt(1, 26);
        req = 2'b11;
        wait_en(4, 500, "t2_start");
        req = 2'b00;
        wait_idle(300, "t2_drain");
        chk("t2_first", 32'(en_at(1)), 1);
        chk("t2_second", 32'(en_at(2)), 0);
        chk("t2_third", 32'(en_at(3)), 1);

        // Backpressure on source 1
        push_pkt(1, 26);
        req = 2'b10;
        wait_en(5, 50, "t3_start");
        req = 2'b00;
        t = 0;
        while ((sb_q.size() != 0 || grant != 2'b00) && t < 600) begin
            rdy = ((t / 2) % 2) == 0;
            step();
            t++;
        end
        rdy = 1'b1;
        if (t >= 600) begin
            vectors++; miscompares++;
            $display("FAIL t3_drain: %0d beats outstanding after bound", sb_q.size());
        end
        chk("t3_src", 32'(en_at(4)), 1);
        chk("t3_no_err", 32'(err_cnt), 0);

        // Stalled source 0, then source 1 served
        stall0 = 1'b1;
        push_pkt(0, 3); push_pkt(1, 26);
        req = 2'b11;
        wait_en(7, 800, "t4_start");
        req = 2'b00;
        stall0 = 1'b0;
        wait_idle(300, "t4_drain");
        chk("t4_first_src", 32'(en_at(5)), 0);
        chk("t4_next_src", 32'(en_at(6)), 1);
        chk("t4_err_pulses", 32'(err_cnt), 1);
        chk("t4_err_after_last_beat", 32'(err_gap), TO);

        // Busy source 0 driving spurious beats
        fbusy0 = 1'b1; spur0 = 1'b1;
        push_pkt(1, 26);
        req = 2'b11;
        wait_en(8, 50, "t5_start");
        req = 2'b00;
        wait_idle(300, "t5_drain");
        spur0 = 1'b0; fbusy0 = 1'b0;
        chk("t5_src", 32'(en_at(7)), 1);

        // Reset at beat 10
        push_pkt(0, 10);
        req = 2'b11;
        base = beats;
        t = 0;
        while (beats < base + 10 && t < 200) begin
            step();
            t++;
        end
        chk("t6_beats_before_reset", 32'(beats - base), 10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_src_en", 32'(src_en), 0);
        chk("t6_rst_src_rdy", 32'(src_rdy), 0);
        chk("t6_rst_dout_vld", 32'(dout_vld), 0);
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_err", 32'(err), 0);
        step(); step();
        have_eop = 1'b0;
        rst_n = 1'b1;
        push_pkt(0, 26);
        wait_en(10, 50, "t6_restart");
        req = 2'b00;
        wait_idle(300, "t6_drain");
        chk("t6_pre_reset_src", 32'(en_at(8)), 0);
        chk("t6_post_reset_src", 32'(en_at(9)), 0);

        chk("sb_drained", 32'(sb_q.size()), 0);
        chk("err_total", 32'(err_cnt), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
